// File: rtl/bgs_pkg.sv
// Shared definitions for the background-subtraction pipeline: frame geometry,
// SRAM statistics word layout, grey-conversion weights and the detector FSM states.
package bgs_pkg;

    localparam int DEF_H_MAX   = 640;
    localparam int DEF_V_MAX   = 480;
    localparam int FRAME_COUNT = 32;

    localparam int PIX_W  = 10;
    localparam int GRAY_W = 8;
    localparam int ADDR_W = 20;
    localparam int DQ_W   = 16;

    // Statistics are stored as two 16-bit words per pixel:
    // word0[11:0] = sum[12:1], word0[15:12] = sumsq[4:1], word1 = sumsq[20:5].
    localparam int W0_SUM_LSB = 0;
    localparam int W0_SUM_MSB = 11;
    localparam int W0_SQ_LSB  = 12;
    localparam int W0_SQ_MSB  = 15;
    localparam int SUM_W      = 13;
    localparam int SQ_W       = 21;
    localparam int STAT_SHIFT = 5;

    localparam logic [6:0] COEF_R = 7'd38;
    localparam logic [6:0] COEF_G = 7'd75;
    localparam logic [6:0] COEF_B = 7'd15;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD0  = 3'd1,
        S_RD1  = 3'd2,
        S_CALC = 3'd3,
        S_OUT  = 3'd4
    } fg_state_e;

    function automatic logic [GRAY_W-1:0] abs_diff8(
        input logic [GRAY_W-1:0] a,
        input logic [GRAY_W-1:0] b
    );
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/rgb2gray.sv
// Fixed-point RGB to 8-bit luma: (38r + 75g + 15b) / 512 on 10-bit channels.
module rgb2gray
    import bgs_pkg::*;
(
    input  logic [PIX_W-1:0]  i_r,
    input  logic [PIX_W-1:0]  i_g,
    input  logic [PIX_W-1:0]  i_b,
    output logic [GRAY_W-1:0] o_gray
);

    logic [17:0] weighted_sum;
    logic        unused_bits;

    // Weights sum to 128, so full-scale input lands exactly at 255.75 -> 255.
    always_comb begin
        weighted_sum = 18'(COEF_R) * 18'(i_r)
                     + 18'(COEF_G) * 18'(i_g)
                     + 18'(COEF_B) * 18'(i_b);
    end

    assign o_gray      = weighted_sum[16:9];
    assign unused_bits = ^{weighted_sum[17], weighted_sum[8:0]};

endmodule

// File: rtl/fg_detect.sv
// Per-pixel foreground test: fetches the pixel's background mean/variance from SRAM
// and flags pixels whose squared grey deviation exceeds K_SIGMA2 * variance.
module fg_detect
    import bgs_pkg::*;
#(
    parameter int H_MAX     = DEF_H_MAX,
    parameter int V_MAX     = DEF_V_MAX,
    parameter int K_SIGMA2  = 9,
    parameter int VAR_FLOOR = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_bg_ready,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [PIX_W-1:0]  i_r,
    input  logic [PIX_W-1:0]  i_g,
    input  logic [PIX_W-1:0]  i_b,
    output logic              o_sram_rd,
    output logic [ADDR_W-1:0] o_sram_addr,
    input  logic [DQ_W-1:0]   i_sram_dq,
    output logic              o_fg_valid,
    output logic              o_fg,
    output logic [GRAY_W-1:0] o_gray,
    output logic              o_frame_end
);

    localparam int HW        = (H_MAX > 1) ? $clog2(H_MAX) : 1;
    localparam int VW        = (V_MAX > 1) ? $clog2(V_MAX) : 1;
    localparam int PIX_IDX_W = ADDR_W - 1;

    fg_state_e         state_q;
    logic [HW-1:0]     h_q;
    logic [VW-1:0]     v_q;
    logic [GRAY_W-1:0] gray_q;
    logic [DQ_W-1:0]   w0_q;
    logic              rd_q;
    logic [ADDR_W-1:0] addr_q;
    logic              fg_valid_q;
    logic              fg_q;
    logic [GRAY_W-1:0] gray_out_q;
    logic              frame_end_q;

    logic [GRAY_W-1:0]    gray_d;
    logic [PIX_IDX_W-1:0] pix_idx;
    logic [SUM_W-1:0]     sum13;
    logic [SQ_W-1:0]      sq21;
    logic [GRAY_W-1:0]    mean;
    logic [15:0]          ex2;
    logic [15:0]          mean_sq;
    logic [15:0]          var_raw;
    logic [15:0]          var_eff;
    logic [GRAY_W-1:0]    dev;
    logic [SQ_W-1:0]      dev_sq;
    logic [SQ_W-1:0]      thresh;
    logic                 fg_d;
    logic                 last_pix;
    logic                 accept;
    logic                 unused_dec;

    rgb2gray u_rgb2gray (
        .i_r    (i_r),
        .i_g    (i_g),
        .i_b    (i_b),
        .o_gray (gray_d)
    );

    // Reset is folded in so the handshake reads 0 while reset is held.
    assign o_ready = (state_q == S_IDLE) && i_bg_ready && !i_rst;
    assign accept  = i_valid && o_ready;

    assign pix_idx  = PIX_IDX_W'(h_q) + PIX_IDX_W'(v_q) * PIX_IDX_W'(H_MAX);
    assign last_pix = (h_q == HW'(H_MAX - 1)) && (v_q == VW'(V_MAX - 1));

    // word1 is evaluated straight off the bus in S_CALC, the cycle it arrives.
    always_comb begin
        sum13   = {w0_q[W0_SUM_MSB:W0_SUM_LSB], 1'b0};
        sq21    = {i_sram_dq, w0_q[W0_SQ_MSB:W0_SQ_LSB], 1'b0};
        mean    = sum13[SUM_W-1:STAT_SHIFT];
        ex2     = sq21[SQ_W-1:STAT_SHIFT];
        mean_sq = 16'(mean) * 16'(mean);
        var_raw = (ex2 >= mean_sq) ? (ex2 - mean_sq) : 16'd0;
        var_eff = (var_raw < 16'(VAR_FLOOR)) ? 16'(VAR_FLOOR) : var_raw;
        dev     = abs_diff8(gray_q, mean);
        dev_sq  = SQ_W'(dev) * SQ_W'(dev);
        thresh  = SQ_W'(K_SIGMA2) * SQ_W'(var_eff);
        fg_d    = dev_sq > thresh;
    end

    assign unused_dec = ^{sum13[STAT_SHIFT-1:0], sq21[STAT_SHIFT-1:0]};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            h_q         <= '0;
            v_q         <= '0;
            gray_q      <= '0;
            w0_q        <= '0;
            rd_q        <= 1'b0;
            addr_q      <= '0;
            fg_valid_q  <= 1'b0;
            fg_q        <= 1'b0;
            gray_out_q  <= '0;
            frame_end_q <= 1'b0;
        end else begin
            rd_q        <= 1'b0;
            addr_q      <= '0;
            fg_valid_q  <= 1'b0;
            frame_end_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        gray_q  <= gray_d;
                        rd_q    <= 1'b1;
                        addr_q  <= {pix_idx, 1'b0};
                        state_q <= S_RD0;
                    end
                end
                S_RD0: begin
                    rd_q    <= 1'b1;
                    addr_q  <= {pix_idx, 1'b1};
                    state_q <= S_RD1;
                end
                S_RD1: begin
                    w0_q    <= i_sram_dq;
                    state_q <= S_CALC;
                end
                S_CALC: begin
                    fg_valid_q  <= 1'b1;
                    fg_q        <= fg_d;
                    gray_out_q  <= gray_q;
                    frame_end_q <= last_pix;
                    state_q     <= S_OUT;
                end
                S_OUT: begin
                    if (h_q == HW'(H_MAX - 1)) begin
                        h_q <= '0;
                        v_q <= (v_q == VW'(V_MAX - 1)) ? '0 : v_q + VW'(1);
                    end else begin
                        h_q <= h_q + HW'(1);
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_sram_rd   = rd_q;
    assign o_sram_addr = addr_q;
    assign o_fg_valid  = fg_valid_q;
    assign o_fg        = fg_q;
    assign o_gray      = gray_out_q;
    assign o_frame_end = frame_end_q;

endmodule

// File: tb/tb_fg_detect.sv
// Self-checking bench for fg_detect: per-cycle comparison against a transaction-level
// model, directed pixels with hand-computed results, and a randomized phase.
module tb_fg_detect;

    localparam int TH   = 8;
    localparam int TV   = 4;
    localparam int NPIX = TH * TV;
    localparam int MEMW = 2 * NPIX;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        bg_ready = 1'b0;
    logic        valid = 1'b0;
    logic [9:0]  r = '0, g = '0, b = '0;
    logic        ready;
    logic        sram_rd;
    logic [19:0] sram_addr;
    logic [15:0] sram_dq = '0;
    logic        fg_valid;
    logic        fg;
    logic [7:0]  gray;
    logic        frame_end;

    fg_detect #(
        .H_MAX     (TH),
        .V_MAX     (TV),
        .K_SIGMA2  (9),
        .VAR_FLOOR (16)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_bg_ready  (bg_ready),
        .i_valid     (valid),
        .o_ready     (ready),
        .i_r         (r),
        .i_g         (g),
        .i_b         (b),
        .o_sram_rd   (sram_rd),
        .o_sram_addr (sram_addr),
        .i_sram_dq   (sram_dq),
        .o_fg_valid  (fg_valid),
        .o_fg        (fg),
        .o_gray      (gray),
        .o_frame_end (frame_end)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM, one-cycle read latency.
    logic [15:0] mem [0:MEMW-1];
    always @(posedge clk) begin
        if (sram_rd) sram_dq <= mem[int'(sram_addr) % MEMW];
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_gray(input int rr, input int gg, input int bb);
        return (38 * rr + 75 * gg + 15 * bb) / 512;
    endfunction

    function automatic int model_fg(input int gr, input int w0, input int w1);
        int mean, ex2, vr, d;
        mean = ((w0 % 4096) * 2) / 32;
        ex2  = (w1 * 32 + (w0 / 4096) * 2) / 32;
        vr   = ex2 - mean * mean;
        if (vr < 0)  vr = 0;
        if (vr < 16) vr = 16;
        d = gr - mean;
        return (d * d > 9 * vr) ? 1 : 0;
    endfunction

    // Transaction-level model: one pixel in flight, results due 4 cycles after accept.
    int cyc = 0;
    int acc_cyc = -100;
    int acc_addr = 0;
    int pix = 0;
    int exp_fg_r = 0, exp_gray_r = 0, exp_fe_r = 0;
    int held_fg = 0, held_gray = 0;
    int since;
    bit exp_rdy, exp_rd;
    int exp_addr;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            check("rst_ready", ready, 0);
            check("rst_rd", sram_rd, 0);
            check("rst_addr", sram_addr, 0);
            check("rst_fg_valid", fg_valid, 0);
            check("rst_fg", fg, 0);
            check("rst_gray", gray, 0);
            check("rst_frame_end", frame_end, 0);
            acc_cyc = -100; pix = 0; held_fg = 0; held_gray = 0;
        end else begin
            since    = cyc - acc_cyc;
            exp_rdy  = bg_ready && !(since >= 1 && since <= 4);
            exp_rd   = (since == 1) || (since == 2);
            exp_addr = (since == 1) ? acc_addr : (since == 2) ? acc_addr + 1 : 0;
            check("ready", ready, int'(exp_rdy));
            check("sram_rd", sram_rd, int'(exp_rd));
            check("sram_addr", sram_addr, exp_addr);
            check("fg_valid", fg_valid, (since == 4) ? 1 : 0);
            if (since == 4) begin
                held_fg   = exp_fg_r;
                held_gray = exp_gray_r;
                check("frame_end", frame_end, exp_fe_r);
                pix = (pix + 1) % NPIX;
            end else begin
                check("frame_end_idle", frame_end, 0);
            end
            check("fg", fg, held_fg);
            check("gray", gray, held_gray);
            if (valid && exp_rdy) begin
                acc_cyc    = cyc;
                acc_addr   = 2 * pix;
                exp_gray_r = model_gray(r, g, b);
                exp_fg_r   = model_fg(exp_gray_r, mem[acc_addr], mem[acc_addr + 1]);
                exp_fe_r   = (pix == NPIX - 1) ? 1 : 0;
            end
        end
    end

    task automatic wait_result(input string tag, output int lat);
        bit got;
        got = 0; lat = 0;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk);
            if (fg_valid) begin got = 1; lat = i; end
        end
        check({tag, "_result_seen"}, int'(got), 1);
    endtask

    task automatic send_pix(input int rr, input int gg, input int bb,
                            input int eg, input int ef, input string tag);
        int n, lat;
        @(posedge clk); #1;
        r = 10'(rr); g = 10'(gg); b = 10'(bb); valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ready && n < 50) begin @(negedge clk); n++; end
        check({tag, "_accept"}, ready, 1);
        @(posedge clk); #1 valid = 1'b0;
        wait_result(tag, lat);
        check({tag, "_latency"}, lat, 4);
        check({tag, "_gray"}, gray, eg);
        check({tag, "_fg"}, fg, ef);
        $display("pixel %s: gray=%0d fg=%0d latency=%0d", tag, gray, fg, lat);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int lat, fe_cnt, m, vr, ex2;
        for (int p = 0; p < NPIX; p++) begin
            m   = int'($urandom % 256);
            vr  = int'($urandom % 700) - 100;
            ex2 = m * m + vr;
            if (ex2 < 0) ex2 = 0;
            if (ex2 > 65535) ex2 = 65535;
            mem[2 * p]     = {4'($urandom), 8'(m), 4'($urandom)};
            mem[2 * p + 1] = 16'(ex2);
        end
        mem[0] = 16'h0640; mem[1] = 16'h2710;
        mem[2] = 16'h0640; mem[3] = 16'h2710;
        mem[4] = 16'h0640; mem[5] = 16'h2710;
        mem[6] = 16'h0640; mem[7] = 16'h0000;
        mem[8] = 16'h0640; mem[9] = 16'h2710;

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        bg_ready = 1'b1;

        send_pix(400, 400, 400, 100, 0, "mean100_gray100");
        send_pix(440, 440, 440, 110, 0, "gray110_d2_100");
        send_pix(480, 480, 480, 120, 1, "gray120_d2_400");
        send_pix(400, 400, 400, 100, 0, "var_clamp_floor");
        send_pix(1023, 1023, 1023, 255, 1, "full_scale");

        // Stalled background: valid held, nothing may be accepted or read.
        @(posedge clk); #1 bg_ready = 1'b0; valid = 1'b1;
        repeat (100) @(posedge clk);
        #1 bg_ready = 1'b1;
        @(negedge clk);
        check("bg_ready_rise_accept", ready, 1);
        @(posedge clk); #1 valid = 1'b0;
        wait_result("after_stall", lat);
        $display("pixel after_stall: gray=%0d fg=%0d", gray, fg);

        // Reset while the second SRAM word is being requested.
        @(posedge clk); #1 valid = 1'b1;
        @(negedge clk);
        check("pre_reset_accept", ready, 1);
        @(posedge clk); #1 valid = 1'b0;
        @(posedge clk); #1;
        check("rd1_strobe", sram_rd, 1);
        check("rd1_addr", sram_addr, 13);
        rst = 1'b1;
        #1;
        check("async_rst_rd", sram_rd, 0);
        check("async_rst_addr", sram_addr, 0);
        check("async_rst_ready", ready, 0);
        repeat (8) @(negedge clk);
        check("no_result_after_rst", fg_valid, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 valid = 1'b1; r = 10'd400; g = 10'd400; b = 10'd400;
        @(negedge clk);
        @(posedge clk); #1 valid = 1'b0;
        @(negedge clk);
        check("post_rst_addr0_rd", sram_rd, 1);
        check("post_rst_addr0", sram_addr, 0);
        wait_result("post_rst", lat);
        check("post_rst_gray", gray, 100);
        $display("pixel post_rst: gray=%0d fg=%0d", gray, fg);

        // Two back-to-back frames: exactly one frame_end per frame.
        pulse_reset();
        @(posedge clk); #1 valid = 1'b1;
        fe_cnt = 0;
        repeat (2 * NPIX * 5 + 3) begin
            @(negedge clk);
            if (frame_end) fe_cnt++;
            @(posedge clk); #1 r = 10'($urandom); g = 10'($urandom); b = 10'($urandom);
        end
        check("frame_end_count", fe_cnt, 2);
        $display("frames streamed: frame_end pulses=%0d", fe_cnt);

        // Randomized traffic with background-ready dropouts.
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            valid = ($urandom % 4) != 0;
            r = 10'($urandom); g = 10'($urandom); b = 10'($urandom);
            if (($urandom % 16) == 0) bg_ready = ~bg_ready;
        end
        @(posedge clk); #1 valid = 1'b0; bg_ready = 1'b1;
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
